axi4_lite_slave_regs: RTL

//  AXI4-Lite slave register bank; direct downstream consumer of axi4_lite_master transactions.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi4_lite_slave_regs_if.sv | 41 ++++
 rtl/axi4_lite_regfile.sv | 43 ++++
 rtl/axi4_lite_slave_regs.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the slave register bank: response codes and the
// state encodings of the independent write and read channel FSMs.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  localparam int unsigned STRB_W = 4;

  function automatic resp_t range_resp(input logic in_range);
    return in_range ? OKAY : SLVERR;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus between a master and the register-bank slave.
// Handshake: a beat transfers on a rising ACLK edge where VALID and READY are
// both 1; VALID, once raised, holds its payload stable until that edge.
interface axi4_lite_slave_regs_if #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDRESS-1:0]      S_AWADDR;
  logic                    S_AWVALID;
  logic                    S_AWREADY;
  logic [DATA_WIDTH-1:0]   S_WDATA;
  logic [DATA_WIDTH/8-1:0] S_WSTRB;
  logic                    S_WVALID;
  logic                    S_WREADY;
  logic [1:0]              S_BRESP;
  logic                    S_BVALID;
  logic                    S_BREADY;
  logic [ADDRESS-1:0]      S_ARADDR;
  logic                    S_ARVALID;
  logic                    S_ARREADY;
  logic [DATA_WIDTH-1:0]   S_RDATA;
  logic [1:0]              S_RRESP;
  logic                    S_RVALID;
  logic                    S_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    input  S_ARADDR, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
    output S_ARADDR, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID
  );

endinterface

// File: rtl/axi4_lite_regfile.sv
// NUM_REGS word registers with one byte-strobed synchronous write port,
// one combinational read port and a flat dump of every register.
module axi4_lite_regfile #(
  parameter  int NUM_REGS   = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  // Reset wins over a write landing on the same edge, so a reset that
  // arrives with a commit pending leaves every register cleared.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem[rd_idx];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[k];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write (AW+W -> B) and read
// (AR -> R) channel FSMs in front of a strobed register file.
module axi4_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  axi4_lite_slave_regs_if.slave          s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output wr_state_t                      dbg_wr_state,
  output rd_state_t                      dbg_rd_state
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDRESS-1:0] MAP_BYTES = ADDRESS'(NUM_REGS * 4);

  // Write channel state
  wr_state_t               wr_state, wr_state_d;
  logic                    aw_held, aw_held_d;
  logic                    w_held, w_held_d;
  logic [ADDRESS-1:0]      awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  resp_t                   bresp_q, bresp_d;
  logic                    awready, wready;
  logic                    wr_in_range;
  logic                    commit;

  // Read channel state
  rd_state_t               rd_state, rd_state_d;
  logic                    rvalid_q, rvalid_d;
  resp_t                   rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    arready;
  logic                    rd_in_range;
  logic [DATA_WIDTH-1:0]   rf_rdata;

  assign wr_in_range = (awaddr_q < MAP_BYTES);
  assign rd_in_range = (s_axi.S_ARADDR < MAP_BYTES);

  axi4_lite_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .wr_en     (commit),
    .wr_idx    (awaddr_q[IDX_W+1:2]),
    .wr_data   (wdata_q),
    .wr_strb   (wstrb_q),
    .rd_idx    (s_axi.S_ARADDR[IDX_W+1:2]),
    .rd_data   (rf_rdata),
    .regs_flat (regs_out)
  );

  // AW and W are captured independently; the commit happens one edge after
  // both are held, which is also the edge that raises BVALID.
  always_comb begin
    wr_state_d = wr_state;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    commit     = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    unique case (wr_state)
      WR_COLLECT: begin
        awready = ARESETN & ~aw_held;
        wready  = ARESETN & ~w_held;
        if (aw_held && w_held) begin
          commit     = wr_in_range;
          bvalid_d   = 1'b1;
          bresp_d    = range_resp(wr_in_range);
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_RESP;
        end else begin
          if (s_axi.S_AWVALID && awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.S_AWADDR;
          end
          if (s_axi.S_WVALID && wready) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_WDATA;
            wstrb_d  = s_axi.S_WSTRB;
          end
        end
      end
      WR_RESP: begin
        if (s_axi.S_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_COLLECT;
        end
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state <= WR_COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      wr_state <= wr_state_d;
      aw_held  <= aw_held_d;
      w_held   <= w_held_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
    end
  end

  // The read port samples storage before any same-edge commit lands, so a
  // colliding read returns the pre-write value.
  always_comb begin
    rd_state_d = rd_state;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    arready    = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        arready = ARESETN;
        if (s_axi.S_ARVALID && arready) begin
          rdata_d    = rd_in_range ? rf_rdata : '0;
          rresp_d    = range_resp(rd_in_range);
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (s_axi.S_RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state <= RD_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_state_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s_axi.S_AWREADY = awready;
  assign s_axi.S_WREADY  = wready;
  assign s_axi.S_BVALID  = bvalid_q;
  assign s_axi.S_BRESP   = bresp_q;
  assign s_axi.S_ARREADY = arready;
  assign s_axi.S_RVALID  = rvalid_q;
  assign s_axi.S_RRESP   = rresp_q;
  assign s_axi.S_RDATA   = rdata_q;

  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;

endmodule
